// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding, one-hot result constants and an index-width helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } cmp_state_t;

  // One-hot result encoding {gt, eq, lt}, compatible with the older comparator.
  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  // Bits needed to hold a slice index 0..n-1; never less than one bit so a
  // single-slice configuration still has a legal counter.
  function automatic int cmp_clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit_compare.sv
// Combinational DIGIT-bit slice comparator. With invert_msb set, the slice
// MSB of both operands is flipped, which turns a two's-complement ordering
// into an unsigned one for the top slice of a signed compare.
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             invert_msb,
  output logic             gt,
  output logic             lt
);

  logic [DIGIT-1:0] msb_mask;
  logic [DIGIT-1:0] xm;
  logic [DIGIT-1:0] ym;

  // Apply the optional sign-bit flip and compare as unsigned.
  always_comb begin
    msb_mask = DIGIT'(invert_msb) << (DIGIT - 1);
    xm       = x ^ msb_mask;
    ym       = y ^ msb_mask;
    gt       = (xm > ym);
    lt       = (xm < ym);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands one DIGIT-bit slice
// per clock from the MSB slice down and stops on the first unequal slice.
//
// Handshake: start is sampled only while the FSM is IDLE or DONE; an accepted
// start latches a, b and signed_mode. busy is high for every COMPARE cycle and
// start is ignored then. done is a one-cycle pulse (DONE state) and r is valid
// from that cycle, holding until the next result or reset. busy and done are
// never high together; start during DONE is accepted with no idle bubble.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [2:0]       r,
  output cmp_state_t       state_dbg
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = cmp_clog2(NDIG);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

  cmp_state_t       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic             s_q;
  logic [2:0]       r_q, r_n;
  logic             load;

  logic [DIGIT-1:0] slice_a, slice_b;
  logic             invert_msb;
  logic             sl_gt, sl_lt;

  // Select the current slice of each latched operand.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (idx == IDX_W'(d)) begin
        slice_a = a_q[d*DIGIT +: DIGIT];
        slice_b = b_q[d*DIGIT +: DIGIT];
      end
    end
    invert_msb = s_q && (idx == IDX_TOP);
  end

  digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
    .x          (slice_a),
    .y          (slice_b),
    .invert_msb (invert_msb),
    .gt         (sl_gt),
    .lt         (sl_lt)
  );

  // Next-state, index and result logic.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    r_n     = r_q;
    load    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          idx_n   = IDX_TOP;
          state_n = ST_COMPARE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (sl_gt) begin
          r_n     = R_GT;
          state_n = ST_DONE;
        end else if (sl_lt) begin
          r_n     = R_LT;
          state_n = ST_DONE;
        end else if (idx == '0) begin
          r_n     = R_EQ;
          state_n = ST_DONE;
        end else begin
          idx_n = idx - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, index, result and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      r_q   <= 3'b000;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      r_q   <= r_n;
      if (load) begin
        a_q <= a;
        b_q <= b;
        s_q <= signed_mode;
      end
    end
  end

  assign busy      = (state == ST_COMPARE);
  assign done      = (state == ST_DONE);
  assign r         = r_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for the sequential magnitude comparator: a 16/4 instance for
// the handshake, latency and reset scenarios and a 4/1 instance swept over
// every operand pair in both modes against a behavioural reference.
module tb_seq_magnitude_comparator;
  import cmp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // 16-bit, 4-bit-slice instance
  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [2:0]  r16;
  cmp_state_t  st16;

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .r(r16), .state_dbg(st16)
  );

  // 4-bit, 1-bit-slice instance
  logic       start4 = 1'b0, sm4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4;
  logic [2:0] r4;
  cmp_state_t st4;

  seq_magnitude_comparator #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .r(r4), .state_dbg(st4)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int overlap16 = 0;
  int overlap4 = 0;

  // From a COMPARE cycle, wait (bounded) for done; n = COMPARE cycles seen.
  task automatic wait_done16(output int n, output int busy_n, output logic [2:0] res);
    n = 0;
    busy_n = 0;
    res = 3'bxxx;
    while (!done16 && n < 20) begin
      if (busy16) busy_n++;
      step();
      n++;
    end
    if (busy16 && done16) overlap16++;
    if (done16) res = r16;
  endtask

  task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic s,
                      output int n, output int busy_n, output logic [2:0] res);
    a16 = av; b16 = bv; sm16 = s; start16 = 1'b1;
    step();
    start16 = 1'b0;
    wait_done16(n, busy_n, res);
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic s,
                     output int n, output logic [2:0] res);
    a4 = av; b4 = bv; sm4 = s; start4 = 1'b1;
    step();
    start4 = 1'b0;
    n = 0;
    res = 3'bxxx;
    while (!done4 && n < 10) begin
      step();
      n++;
    end
    if (busy4 && done4) overlap4++;
    if (done4) res = r4;
  endtask

  // Behavioural reference: integer compare of the operand values.
  function automatic logic [2:0] ref_cmp(input logic [3:0] av, input logic [3:0] bv, input logic s);
    int ia, ib;
    ia = s ? int'($signed(av)) : int'(av);
    ib = s ? int'($signed(bv)) : int'(bv);
    if (ia > ib) return 3'b100;
    if (ia < ib) return 3'b001;
    return 3'b010;
  endfunction

  // Expected slice count for DIGIT=1: position of first differing bit from MSB.
  function automatic int ref_slices(input logic [3:0] av, input logic [3:0] bv);
    for (int k = 3; k >= 0; k--) begin
      if (av[k] != bv[k]) return 4 - k;
    end
    return 4;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int n, bn, pulses;
    logic [2:0] res;

    // Reset state
    #12;
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_done16", 32'(done16), 32'd0);
    chk("rst_r16", 32'(r16), 32'd0);
    chk("rst_state16", 32'(st16), 32'(ST_IDLE));
    chk("rst_r4", 32'(r4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_state16", 32'(st16), 32'(ST_IDLE));

    // 1: unsigned, differs in the last slice
    op16(16'h1234, 16'h1235, 1'b0, n, bn, res);
    chk("t1_r", 32'(res), 32'b001);
    chk("t1_latency", 32'(n), 32'd4);
    chk("t1_busy_cycles", 32'(bn), 32'd4);
    step();
    chk("t1_done_pulse", 32'(done16), 32'd0);
    chk("t1_back_idle", 32'(st16), 32'(ST_IDLE));

    // 2: top slice decides, unsigned vs signed
    op16(16'hF000, 16'h0FFF, 1'b0, n, bn, res);
    chk("t2u_r", 32'(res), 32'b100);
    chk("t2u_latency", 32'(n), 32'd1);
    op16(16'hF000, 16'h0FFF, 1'b1, n, bn, res);
    chk("t2s_r", 32'(res), 32'b001);
    chk("t2s_latency", 32'(n), 32'd1);

    // 3: equal operands, then back-to-back start in the DONE cycle
    op16(16'hABCD, 16'hABCD, 1'b0, n, bn, res);
    chk("t3u_r", 32'(res), 32'b010);
    chk("t3u_latency", 32'(n), 32'd4);
    op16(16'hABCD, 16'hABCD, 1'b1, n, bn, res);
    chk("t3s_r", 32'(res), 32'b010);
    chk("t3s_latency", 32'(n), 32'd4);
    op16(16'h0000, 16'h0000, 1'b0, n, bn, res);
    chk("t3z_r", 32'(res), 32'b010);
    chk("t3z_latency", 32'(n), 32'd4);
    chk("t3z_in_done", 32'(done16), 32'd1);
    a16 = 16'h0005; b16 = 16'h0003; sm16 = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    chk("t3_b2b_busy", 32'(busy16), 32'd1);
    chk("t3_b2b_state", 32'(st16), 32'(ST_COMPARE));
    chk("t3_b2b_r_hold", 32'(r16), 32'b010);
    wait_done16(n, bn, res);
    chk("t3_b2b_r", 32'(res), 32'b100);
    chk("t3_b2b_latency", 32'(n), 32'd4);

    // 4: start and operand changes during COMPARE are ignored
    a16 = 16'h0001; b16 = 16'h0002; sm16 = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    step();
    a16 = 16'hFFFF; b16 = 16'h0000; sm16 = 1'b1; start16 = 1'b1;
    step();
    start16 = 1'b0;
    pulses = 0;
    res = 3'bxxx;
    for (int i = 0; i < 10; i++) begin
      if (done16) begin
        pulses++;
        res = r16;
      end
      if (busy16 && done16) overlap16++;
      step();
    end
    chk("t4_pulses", 32'(pulses), 32'd1);
    chk("t4_r", 32'(res), 32'b001);

    // 5: asynchronous reset mid-compare
    a16 = 16'h0001; b16 = 16'h0002; sm16 = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    step();
    chk("t5_busy_before", 32'(busy16), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy16), 32'd0);
    chk("t5_rst_done", 32'(done16), 32'd0);
    chk("t5_rst_r", 32'(r16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done16) pulses++;
    end
    chk("t5_no_spurious_done", 32'(pulses), 32'd0);
    chk("t5_state_idle", 32'(st16), 32'(ST_IDLE));
    op16(16'h8000, 16'h7FFF, 1'b1, n, bn, res);
    chk("t5_after_r", 32'(res), 32'b001);
    chk("t5_after_latency", 32'(n), 32'd1);

    // 6: exhaustive 4-bit, 1-bit slices, both modes
    op4(4'b1000, 4'b0111, 1'b1, n, res);
    chk("t6_8v7_signed", 32'(res), 32'b001);
    op4(4'b1000, 4'b0111, 1'b0, n, res);
    chk("t6_8v7_unsigned", 32'(res), 32'b100);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          op4(4'(i), 4'(j), 1'(s), n, res);
          chk($sformatf("t6_r_%0d_%0d_s%0d", i, j, s), 32'(res), 32'(ref_cmp(4'(i), 4'(j), 1'(s))));
          chk($sformatf("t6_n_%0d_%0d_s%0d", i, j, s), 32'(n), 32'(ref_slices(4'(i), 4'(j))));
          chk($sformatf("t6_onehot_%0d_%0d_s%0d", i, j, s), 32'($onehot(res)), 32'd1);
        end
      end
    end

    chk("busy_done_overlap16", 32'(overlap16), 32'd0);
    chk("busy_done_overlap4", 32'(overlap4), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
